// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub
//   Registered WIDTH-bit adder/subtractor with carry-in. The carry chain is cut
//   into STAGES equal segments; each segment adds its slice using the carry
//   registered by the previous segment. Latency is STAGES cycles with a
//   valid/ready handshake and full backpressure.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand set present
//   in_ready   operand set accepted this cycle (= ~out_valid | out_ready)
//   a, b       operands
//   cin        carry-in (add) / borrow-in (sub)
//   sub        0 = a + b + cin, 1 = a - b - cin
//   out_valid  result present
//   out_ready  downstream accepts the result
//   s          sum / difference
//   cout       carry-out; for subtraction 1 = no borrow
//   ovf        signed two's-complement overflow
//   zero       s == 0
module pipelined_add_sub #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned SEG = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_add_sub: illegal segmentation WIDTH=%0d STAGES=%0d", WIDTH, STAGES);
  end

  // The whole pipeline moves as one unit: it advances whenever the output
  // register is empty or being drained this cycle.
  logic             adv;
  logic [WIDTH-1:0] bx;
  logic             c0;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign bx       = sub ? ~b : b;
  assign c0       = sub ? ~cin : cin;

  // Stage k holds: the finished low (k+1)*SEG sum bits, the carry out of its
  // segment, and (except for the last stage) the still-unused operand bits
  // plus the two sign bits needed for the overflow decision at the end.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned REM  = WIDTH - k * SEG;   // operand bits not yet added
    localparam int unsigned DONE = (k + 1) * SEG;     // sum bits finished after this stage

    logic            in_v;
    logic            in_c;
    logic            in_sa;
    logic            in_sb;
    logic [REM-1:0]  rem_a;
    logic [REM-1:0]  rem_b;
    logic [SEG:0]    seg_sum;
    logic [DONE-1:0] sum_d;
    logic            load;

    logic            v_q;
    logic            c_q;
    logic [DONE-1:0] sum_q;

    if (k == 0) begin : g_src
      assign in_v  = in_valid;
      assign in_c  = c0;
      assign rem_a = a;
      assign rem_b = bx;
      assign in_sa = a[WIDTH-1];
      assign in_sb = bx[WIDTH-1];
      assign sum_d = seg_sum[SEG-1:0];
    end else begin : g_src
      assign in_v  = g_stage[k-1].v_q;
      assign in_c  = g_stage[k-1].c_q;
      assign rem_a = g_stage[k-1].g_fwd.a_hi_q;
      assign rem_b = g_stage[k-1].g_fwd.b_hi_q;
      assign in_sa = g_stage[k-1].g_fwd.sa_q;
      assign in_sb = g_stage[k-1].g_fwd.sb_q;
      assign sum_d = {seg_sum[SEG-1:0], g_stage[k-1].sum_q};
    end

    assign seg_sum = {1'b0, rem_a[SEG-1:0]} + {1'b0, rem_b[SEG-1:0]} + {{SEG{1'b0}}, in_c};

    // Data registers only capture real operands; bubbles move the valid bit
    // but leave data untouched, so the outputs keep their last result while
    // out_valid is low.
    assign load = adv & in_v;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else begin
        if (adv) begin
          v_q <= in_v;
        end
        if (load) begin
          c_q   <= seg_sum[SEG];
          sum_q <= sum_d;
        end
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      // Skew registers: operand bits above this segment and the sign bits.
      logic [REM-SEG-1:0] a_hi_q;
      logic [REM-SEG-1:0] b_hi_q;
      logic               sa_q;
      logic               sb_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_hi_q <= '0;
          b_hi_q <= '0;
          sa_q   <= 1'b0;
          sb_q   <= 1'b0;
        end else if (load) begin
          a_hi_q <= rem_a[REM-1:SEG];
          b_hi_q <= rem_b[REM-1:SEG];
          sa_q   <= in_sa;
          sb_q   <= in_sb;
        end
      end
    end else begin : g_last
      // Flags are resolved as the final segment completes so they register
      // alongside s and cout.
      logic ovf_q;
      logic zero_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (load) begin
          ovf_q  <= (in_sa == in_sb) && (sum_d[WIDTH-1] != in_sa);
          zero_q <= ~|sum_d;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign s         = g_stage[STAGES-1].sum_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_q;
  assign zero      = g_stage[STAGES-1].g_last.zero_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Testbench for pipelined_add_sub: directed checks on a WIDTH=16/STAGES=2
// instance plus randomised parameter sweeps, all through a scoreboard.
module tb_pipelined_add_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- main DUT
  logic        rst_n = 1'b1;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
  logic [15:0] a, b, s;

  pipelined_add_sub #(.WIDTH(16), .STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf), .zero(zero)
  );

  // packed expectation: {cout, ovf, zero, s}
  function automatic logic [18:0] pack16(input logic [15:0] xs, input logic c, input logic o, input logic z);
    return {c, o, z, xs};
  endfunction

  function automatic logic [18:0] model16(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic sb);
    logic [15:0] bxv;
    logic        c0v;
    logic [16:0] r;
    bxv = sb ? ~y : y;
    c0v = sb ? ~ci : ci;
    r   = {1'b0, x} + {1'b0, bxv} + {16'd0, c0v};
    return {r[16], (x[15] == bxv[15]) && (r[15] != x[15]), r[15:0] == 16'd0, r[15:0]};
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [18:0] mq_e[$];
  int          mq_c[$];
  bit          mq_l[$];
  logic [18:0] m_e;
  int          m_c;
  bit          m_l;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (mq_e.size() == 0) begin
        check_eq("spurious_out", 64'(out_valid), 64'd0);
      end else begin
        m_e = mq_e.pop_front();
        m_c = mq_c.pop_front();
        m_l = mq_l.pop_front();
        check_eq("s", 64'(s), 64'(m_e[15:0]));
        check_eq("cout", 64'(cout), 64'(m_e[18]));
        check_eq("ovf", 64'(ovf), 64'(m_e[17]));
        check_eq("zero", 64'(zero), 64'(m_e[16]));
        if (m_l) check_eq("latency", 64'(cyc - m_c), 64'd2);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                      input logic xs, input logic [18:0] e, input bit lat);
    bit done = 1'b0;
    a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        mq_e.push_back(e);
        mq_c.push_back(cyc);
        mq_l.push_back(lat);
        done = 1'b1;
      end
      @(posedge clk);
      #2;
    end
    if (!done) check_eq("accept_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic send_m(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                        input logic xs, input bit lat);
    send(xa, xb, xc, xs, model16(xa, xb, xc, xs), lat);
  endtask

  // ----------------------------------------------------------- sweep DUTs
  function automatic int unsigned sw_width(input int i);
    case (i)
      0: return 16;
      1: return 16;
      2: return 32;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned sw_stages(input int i);
    case (i)
      0: return 1;
      1: return 4;
      2: return 4;
      default: return 8;
    endcase
  endfunction

  bit sw_done [4];

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int unsigned W = sw_width(g);
    localparam int unsigned S = sw_stages(g);

    logic         sr_n = 1'b1;
    logic         iv, ir, ov, ordy, ci, sb, co, of, zr;
    logic [W-1:0] ia, ib, so;
    logic [W+2:0] q_e[$];
    int           q_c[$];
    bit           q_l[$];

    pipelined_add_sub #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk(clk), .rst_n(sr_n), .in_valid(iv), .in_ready(ir),
      .a(ia), .b(ib), .cin(ci), .sub(sb),
      .out_valid(ov), .out_ready(ordy),
      .s(so), .cout(co), .ovf(of), .zero(zr)
    );

    initial begin
      logic [W+2:0] e;
      logic [W-1:0] bxv, held;
      logic [W:0]   r;
      logic         c0v;
      bit           stalled, ph2, ll;
      int           sent, cy, lc;
      string        tg;
      tg = $sformatf("w%0d_s%0d", W, S);
      iv = 1'b0; ordy = 1'b0; ia = '0; ib = '0; ci = 1'b0; sb = 1'b0;
      stalled = 1'b0; held = '0; sent = 0; ph2 = 1'b0;
      #1;
      sr_n = 1'b0;
      repeat (3) @(negedge clk);
      sr_n = 1'b1;
      for (cy = 0; cy < 8000 && (sent < 1020 || q_e.size() != 0); cy++) begin
        @(negedge clk);
        // last 20 ops: continuous out_ready, back-to-back, latency checked
        ph2  = (sent >= 1000);
        ordy = ph2 || ($urandom_range(3) != 0);
        iv   = (sent < 1020) && (ph2 || $urandom_range(3) != 0);
        ia   = ($urandom_range(7) == 0) ? '1 : W'($urandom);
        ib   = ($urandom_range(7) == 0) ? ia : W'($urandom);
        ci   = 1'($urandom_range(1));
        sb   = 1'($urandom_range(1));
        #1;
        if (stalled) begin
          check_eq({tg, "_hold_s"}, 64'(so), 64'(held));
          check_eq({tg, "_hold_v"}, 64'(ov), 64'd1);
        end
        if (ov && ordy) begin
          if (q_e.size() == 0) begin
            check_eq({tg, "_spurious"}, 64'(ov), 64'd0);
          end else begin
            e  = q_e.pop_front();
            lc = q_c.pop_front();
            ll = q_l.pop_front();
            check_eq({tg, "_s"}, 64'(so), 64'(e[W-1:0]));
            check_eq({tg, "_cout"}, 64'(co), 64'(e[W+2]));
            check_eq({tg, "_ovf"}, 64'(of), 64'(e[W+1]));
            check_eq({tg, "_zero"}, 64'(zr), 64'(e[W]));
            if (ll) check_eq({tg, "_lat"}, 64'(cy - lc), 64'(S));
          end
        end
        stalled = ov && !ordy;
        held    = so;
        if (iv && ir) begin
          bxv = sb ? ~ib : ib;
          c0v = sb ? ~ci : ci;
          r   = {1'b0, ia} + {1'b0, bxv} + {{W{1'b0}}, c0v};
          e   = {r[W], (ia[W-1] == bxv[W-1]) && (r[W-1] != ia[W-1]), r[W-1:0] == '0, r[W-1:0]};
          q_e.push_back(e);
          q_c.push_back(cy);
          q_l.push_back(ph2);
          sent++;
        end
      end
      iv = 1'b0;
      check_eq({tg, "_sent"}, 64'(sent), 64'd1020);
      check_eq({tg, "_drain"}, 64'(q_e.size()), 64'd0);
      sw_done[g] = 1'b1;
    end
  end

  // ------------------------------------------------------- directed tests
  initial begin
    logic [15:0] held;
    int          n;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    held = '0;
    #1;
    rst_n = 1'b0;
    #2;
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_ready", 64'(in_ready), 64'd1);
    check_eq("rst_s", 64'(s), 64'd0);
    check_eq("rst_cout", 64'(cout), 64'd0);
    check_eq("rst_ovf", 64'(ovf), 64'd0);
    check_eq("rst_zero", 64'(zero), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // arithmetic corners, back-to-back, continuous out_ready
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, pack16(16'h0000, 1'b1, 1'b0, 1'b1), 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, pack16(16'h8000, 1'b0, 1'b1, 1'b0), 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1, pack16(16'h7FFF, 1'b1, 1'b1, 1'b0), 1'b1);
    send(16'h1234, 16'h1234, 1'b0, 1'b1, pack16(16'h0000, 1'b1, 1'b0, 1'b1), 1'b1);
    send(16'h00FF, 16'h0000, 1'b1, 1'b0, pack16(16'h0100, 1'b0, 1'b0, 1'b0), 1'b1);
    for (int i = 0; i < 6; i++)
      send_m(16'($urandom), 16'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1);
    send(16'h0005, 16'h0007, 1'b1, 1'b1, pack16(16'hFFFD, 1'b0, 1'b0, 1'b0), 1'b1);
    in_valid = 1'b0;

    // outputs keep the last result once the pipe has drained
    repeat (5) @(negedge clk);
    check_eq("hold_valid", 64'(out_valid), 64'd0);
    check_eq("hold_s", 64'(s), 64'hFFFD);
    check_eq("hold_cout", 64'(cout), 64'd0);
    @(posedge clk);
    #2;

    // backpressure: 4 back-to-back ops, 3-cycle stall once out_valid rises
    fork
      begin
        for (int i = 0; i < 4; i++)
          send_m(16'($urandom), 16'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
        in_valid = 1'b0;
      end
      begin
        n = 0;
        while (!out_valid && n < 20) begin
          @(posedge clk);
          #1;
          n++;
        end
        check_eq("bp_rise", 64'(out_valid), 64'd1);
        out_ready = 1'b0;
        held = s;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check_eq("bp_in_ready", 64'(in_ready), 64'd0);
          check_eq("bp_valid", 64'(out_valid), 64'd1);
          check_eq("bp_s_stable", 64'(s), 64'(held));
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check_eq("bp_thru_valid", 64'(out_valid), 64'd1);
          check_eq("bp_thru_ready", 64'(in_ready), 64'd1);
        end
      end
    join
    repeat (4) @(negedge clk);
    check_eq("bp_drain", 64'(mq_e.size()), 64'd0);
    @(posedge clk);
    #2;

    // reset mid-flight with two results in the pipe
    send_m(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    send_m(16'h0F0F, 16'h0101, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1;
    check_eq("pre_rst_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    mq_e.delete();
    mq_c.delete();
    mq_l.delete();
    #1;
    check_eq("mid_rst_valid", 64'(out_valid), 64'd0);
    check_eq("mid_rst_s", 64'(s), 64'd0);
    check_eq("mid_rst_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    send(16'h4000, 16'h4000, 1'b0, 1'b0, pack16(16'h8000, 1'b0, 1'b1, 1'b0), 1'b1);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("post_rst_drain", 64'(mq_e.size()), 64'd0);
    check_eq("post_rst_s", 64'(s), 64'h8000);

    // wait for the parameter sweeps
    for (n = 0; n < 20000 && !(sw_done[0] && sw_done[1] && sw_done[2] && sw_done[3]); n++)
      @(negedge clk);
    check_eq("sweep_done", 64'({sw_done[3], sw_done[2], sw_done[1], sw_done[0]}), 64'hF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
